// File: rtl/proto_field_lookup.sv
// proto_field_lookup: runtime-loadable protobuf schema lookup engine.
// Tracks the decoder's embedded-message path on an ID stack and resolves
// (path snapshot, field id) to field metadata via a MSG -> FIELD slot walk.
// Optional statistics counters are enabled by defining PROTO_LOOKUP_STATS_EN.
module proto_field_lookup #(
    parameter int ID_W     = 4,
    parameter int DEPTH    = 3,
    parameter int NUM_MSGS = 3,
    parameter int FIELDS   = 4,
    parameter int OFS_W    = 8,
    localparam int META_W  = ID_W + OFS_W + 6,
    localparam int MSG_W   = (NUM_MSGS > 1) ? $clog2(NUM_MSGS) : 1,
    localparam int FLD_W   = (FIELDS > 1) ? $clog2(FIELDS) : 1,
    localparam int DEP_W   = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_path_we,
    input  logic [DEPTH*ID_W-1:0] cfg_path,
    input  logic                  cfg_meta_we,
    input  logic [MSG_W-1:0]      cfg_msg,
    input  logic [FLD_W-1:0]      cfg_field,
    input  logic [META_W-1:0]     cfg_meta,
    input  logic                  push,
    input  logic [ID_W-1:0]       push_id,
    input  logic                  pop,
    output logic [DEP_W-1:0]      depth,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ID_W-1:0]       req_id,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_hit,
    output logic [MSG_W-1:0]      rsp_msg,
    output logic [META_W-1:0]     rsp_meta,
    input  logic                  err_clr,
    output logic [2:0]            err
`ifdef PROTO_LOOKUP_STATS_EN
    ,
    output logic [15:0]           hit_cnt,
    output logic [15:0]           miss_cnt
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_MSG, S_FIELD, S_RESP} state_t;

    state_t                  state_q;
    logic [ID_W-1:0]         stack_q [DEPTH];
    logic [ID_W-1:0]         stack_d [DEPTH];
    logic [DEP_W-1:0]        depth_q, depth_d;
    logic [2:0]              err_q, err_d;
    logic                    ovf_ev, unf_ev, cfg_drop_ev;
    logic [DEPTH*ID_W-1:0]   path_tab_q [NUM_MSGS];
    logic [META_W-1:0]       meta_tab_q [NUM_MSGS][FIELDS];
    logic [DEPTH*ID_W-1:0]   cur_path, snap_q;
    logic [ID_W-1:0]         req_id_q;
    logic [MSG_W-1:0]        msg_q, match_idx;
    logic                    match_any;
    logic [FLD_W-1:0]        slot_q;
    logic [META_W-1:0]       slot_meta;
    logic                    slot_hit, in_idle;
    logic                    req_ready_q, rsp_valid_q, rsp_hit_q;
    logic [MSG_W-1:0]        rsp_msg_q;
    logic [META_W-1:0]       rsp_meta_q;

    assign in_idle     = (state_q == S_IDLE);
    assign cfg_drop_ev = !in_idle && (cfg_path_we || cfg_meta_we);

    // Stack next-state: pop is applied first, so push+pop replaces the top entry.
    always_comb begin
        stack_d = stack_q;
        depth_d = depth_q;
        ovf_ev  = 1'b0;
        unf_ev  = 1'b0;
        if (pop) begin
            if (depth_q == '0) begin
                unf_ev = 1'b1;
            end else begin
                stack_d[depth_q - DEP_W'(1)] = '0;
                depth_d = depth_q - DEP_W'(1);
            end
        end
        if (push) begin
            if (depth_d == DEP_W'(DEPTH)) begin
                ovf_ev = 1'b1;
            end else begin
                stack_d[depth_d] = push_id;
                depth_d = depth_d + DEP_W'(1);
            end
        end
        err_d = (err_clr ? 3'b000 : err_q) | {cfg_drop_ev, unf_ev, ovf_ev};
    end

    // Current path: stack levels at or above the occupancy read as zero.
    always_comb begin
        cur_path = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (i < 32'(depth_q)) cur_path[i*ID_W +: ID_W] = stack_q[i];
        end
    end

    // Message match against the snapshot; lowest matching index wins.
    always_comb begin
        match_any = 1'b0;
        match_idx = '0;
        for (int unsigned i = 0; i < NUM_MSGS; i++) begin
            if (!match_any && path_tab_q[i] == snap_q) begin
                match_any = 1'b1;
                match_idx = MSG_W'(i);
            end
        end
    end

    // Field slot compare; id 0 marks an empty slot and never matches.
    always_comb begin
        slot_meta = meta_tab_q[msg_q][slot_q];
        slot_hit  = (slot_meta[ID_W-1:0] == req_id_q) && (req_id_q != '0);
    end

    // Stack, occupancy and sticky error register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) stack_q[i] <= '0;
            depth_q <= '0;
            err_q   <= '0;
        end else begin
            stack_q <= stack_d;
            depth_q <= depth_d;
            err_q   <= err_d;
        end
    end

    // Schema tables: writable only while the engine is idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned m = 0; m < NUM_MSGS; m++) begin
                path_tab_q[m] <= '0;
                for (int unsigned f = 0; f < FIELDS; f++) meta_tab_q[m][f] <= '0;
            end
        end else if (in_idle && 32'(cfg_msg) < NUM_MSGS) begin
            if (cfg_path_we) path_tab_q[cfg_msg] <= cfg_path;
            if (cfg_meta_we && 32'(cfg_field) < FIELDS) meta_tab_q[cfg_msg][cfg_field] <= cfg_meta;
        end
    end

    // Lookup FSM with registered handshake and response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_msg_q   <= '0;
            rsp_meta_q  <= '0;
            req_id_q    <= '0;
            snap_q      <= '0;
            msg_q       <= '0;
            slot_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        req_id_q    <= req_id;
                        snap_q      <= cur_path;
                        req_ready_q <= 1'b0;
                        state_q     <= S_MSG;
                    end
                end
                S_MSG: begin
                    if (match_any) begin
                        msg_q   <= match_idx;
                        slot_q  <= '0;
                        state_q <= S_FIELD;
                    end else begin
                        rsp_valid_q <= 1'b1;
                        rsp_hit_q   <= 1'b0;
                        rsp_msg_q   <= '0;
                        rsp_meta_q  <= '0;
                        state_q     <= S_RESP;
                    end
                end
                S_FIELD: begin
                    if (slot_hit) begin
                        rsp_valid_q <= 1'b1;
                        rsp_hit_q   <= 1'b1;
                        rsp_msg_q   <= msg_q;
                        rsp_meta_q  <= slot_meta;
                        state_q     <= S_RESP;
                    end else if (slot_q == FLD_W'(FIELDS - 1)) begin
                        rsp_valid_q <= 1'b1;
                        rsp_hit_q   <= 1'b0;
                        rsp_msg_q   <= msg_q;
                        rsp_meta_q  <= '0;
                        state_q     <= S_RESP;
                    end else begin
                        slot_q <= slot_q + FLD_W'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef PROTO_LOOKUP_STATS_EN
    logic [15:0] hit_cnt_q, miss_cnt_q;

    // Saturating hit/miss counters, advanced on each accepted response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (err_clr) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (rsp_valid_q && rsp_ready) begin
            if (rsp_hit_q && hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
            if (!rsp_hit_q && miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

    assign depth     = depth_q;
    assign err       = err_q;
    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_hit   = rsp_hit_q;
    assign rsp_msg   = rsp_msg_q;
    assign rsp_meta  = rsp_meta_q;

endmodule

// File: tb/tb_proto_field_lookup.sv
// Directed self-checking bench for proto_field_lookup (default parameters).
module tb_proto_field_lookup;

    localparam logic [3:0] A = 4'd1, B = 4'd2, C = 4'd5, D = 4'd6;
    // metadata = {rep, req, ofs[7:0], emb, dtype[2:0], id[3:0]}
    localparam logic [17:0] M00 = {1'b1, 1'b0, 8'h04, 1'b1, 3'd1, 4'd3};
    localparam logic [17:0] M10 = {1'b0, 1'b0, 8'h00, 1'b0, 3'd1, 4'd1};
    localparam logic [17:0] M11 = {1'b0, 1'b0, 8'h02, 1'b0, 3'd0, 4'd2};
    localparam logic [17:0] M12 = {1'b0, 1'b1, 8'h10, 1'b0, 3'd2, 4'd3};
    localparam logic [17:0] M21 = {1'b0, 1'b1, 8'h20, 1'b0, 3'd5, 4'd4};
    localparam logic [17:0] ALT = {1'b0, 1'b1, 8'h44, 1'b0, 3'd2, 4'd3};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_path_we = 1'b0, cfg_meta_we = 1'b0;
    logic [11:0] cfg_path = '0;
    logic [1:0]  cfg_msg = '0, cfg_field = '0;
    logic [17:0] cfg_meta = '0;
    logic        push = 1'b0, pop = 1'b0;
    logic [3:0]  push_id = '0, req_id = '0;
    logic [1:0]  depth;
    logic        req_valid = 1'b0, req_ready;
    logic        rsp_valid, rsp_ready = 1'b1, rsp_hit;
    logic [1:0]  rsp_msg;
    logic [17:0] rsp_meta;
    logic        err_clr = 1'b0;
    logic [2:0]  err;
`ifdef PROTO_LOOKUP_STATS_EN
    logic [15:0] hit_cnt, miss_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    proto_field_lookup #(.ID_W(4), .DEPTH(3), .NUM_MSGS(3), .FIELDS(4), .OFS_W(8)) dut (
        .clk(clk), .rst(rst),
        .cfg_path_we(cfg_path_we), .cfg_path(cfg_path), .cfg_meta_we(cfg_meta_we),
        .cfg_msg(cfg_msg), .cfg_field(cfg_field), .cfg_meta(cfg_meta),
        .push(push), .push_id(push_id), .pop(pop), .depth(depth),
        .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
        .rsp_msg(rsp_msg), .rsp_meta(rsp_meta), .err_clr(err_clr), .err(err)
`ifdef PROTO_LOOKUP_STATS_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_path(input logic [1:0] m, input logic [11:0] p);
        cfg_path_we = 1'b1; cfg_msg = m; cfg_path = p;
        tick();
        cfg_path_we = 1'b0;
    endtask

    task automatic write_meta(input logic [1:0] m, input logic [1:0] f, input logic [17:0] v);
        cfg_meta_we = 1'b1; cfg_msg = m; cfg_field = f; cfg_meta = v;
        tick();
        cfg_meta_we = 1'b0;
    endtask

    task automatic stk(input logic ps, input logic [3:0] id, input logic pp);
        push = ps; push_id = id; pop = pp;
        tick();
        push = 1'b0; pop = 1'b0;
    endtask

    // Issues one lookup with rsp_ready high; latency counts cycles from the
    // acceptance cycle T, so rsp_valid seen in cycle T+n gives n.
    task automatic run_req(input string tag, input logic [3:0] id, input int exp_lat,
                           input logic exp_hit, input logic [1:0] exp_msg,
                           input logic [17:0] exp_meta, input logic mid_push);
        int cnt;
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_id = id;
        tick();
        req_valid = 1'b0;
        if (mid_push) begin push = 1'b1; push_id = B; end
        cnt = 1;
        while (!rsp_valid && cnt < 20) begin
            tick();
            push = 1'b0;
            cnt++;
        end
        push = 1'b0;
        check({tag, "_lat"}, cnt, exp_lat);
        check({tag, "_hit"}, rsp_hit, exp_hit);
        if (exp_hit) check({tag, "_msg"}, rsp_msg, exp_msg);
        check({tag, "_meta"}, rsp_meta, exp_meta);
        tick();
        check({tag, "_ready"}, req_ready, 1'b1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_depth", depth, 0);
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_hit", rsp_hit, 0);
        check("rst_rsp_msg", rsp_msg, 0);
        check("rst_rsp_meta", rsp_meta, 0);
        check("rst_err", err, 0);

        write_path(2'd0, {4'd0, 4'd0, A});
        write_path(2'd1, {4'd0, B, A});
        write_path(2'd2, {C, B, A});
        write_meta(2'd0, 2'd0, M00);
        write_meta(2'd1, 2'd0, M10);
        write_meta(2'd1, 2'd1, M11);
        write_meta(2'd1, 2'd2, M12);
        write_meta(2'd2, 2'd1, M21);

        stk(1'b1, A, 1'b0);
        stk(1'b1, B, 1'b0);
        check("push_ab_depth", depth, 2);
        run_req("hit3", 4'd3, 5, 1'b1, 2'd1, M12, 1'b0);
        run_req("miss7", 4'd7, 6, 1'b0, 2'd1, 18'd0, 1'b0);
        run_req("miss0", 4'd0, 6, 1'b0, 2'd1, 18'd0, 1'b0);

        stk(1'b1, C, 1'b0);
        check("push_c_depth", depth, 3);
        run_req("hit_msg2", 4'd4, 4, 1'b1, 2'd2, M21, 1'b0);
        stk(1'b1, D, 1'b0);
        check("ovf_depth", depth, 3);
        check("ovf_err", err, 3'b001);
        repeat (4) stk(1'b0, 4'd0, 1'b1);
        check("unf_depth", depth, 0);
        check("unf_err", err, 3'b011);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_clr", err, 0);

        run_req("empty_path", 4'd3, 2, 1'b0, 2'd0, 18'd0, 1'b0);

        stk(1'b1, A, 1'b0);
        run_req("snapshot", 4'd3, 3, 1'b1, 2'd0, M00, 1'b1);
        check("snapshot_depth", depth, 2);

        // Write attempted while the engine walks the field slots, then a stall.
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_id = 4'd3;
        tick();
        req_valid = 1'b0;
        tick();
        cfg_meta_we = 1'b1; cfg_msg = 2'd1; cfg_field = 2'd2; cfg_meta = ALT;
        tick();
        cfg_meta_we = 1'b0;
        check("cfg_busy_err", err, 3'b100);
        tick();
        tick();
        check("stall_valid0", rsp_valid, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid", rsp_valid, 1);
            check("stall_meta", rsp_meta, M12);
            check("stall_msg", rsp_msg, 1);
        end
        rsp_ready = 1'b1;
        tick();
        check("release_valid", rsp_valid, 0);
        check("release_ready", req_ready, 1);

        write_meta(2'd1, 2'd2, ALT);
        run_req("idle_write", 4'd3, 5, 1'b1, 2'd1, ALT, 1'b0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_clr2", err, 0);

        // Asynchronous reset in the middle of a lookup.
        req_valid = 1'b1; req_id = 4'd3;
        tick();
        req_valid = 1'b0;
        tick();
        check("pre_rst_ready", req_ready, 0);
        #2 rst = 1'b1;
        #1;
        check("midrst_ready", req_ready, 1);
        check("midrst_valid", rsp_valid, 0);
        check("midrst_depth", depth, 0);
        #2 rst = 1'b0;
        tick();
        check("post_rst_valid", rsp_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
